// File: rtl/fir_poly_par_pkg.sv
// Shared sizing helpers and output rounding for the P-lane parallel FIR.
package fir_pkg;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

  function automatic int w_acc(input int w_in, input int w_c, input int ntap);
    return w_in + w_c + clog2(ntap);
  endfunction

  function automatic int lat(input int ntap);
    return 1 + clog2(ntap);
  endfunction

  // Operand count remaining after lvl pairwise-add levels (odd one passes through).
  function automatic int tree_nodes(input int n, input int lvl);
    int r;
    r = n;
    for (int i = 0; i < lvl; i++) r = (r + 1) / 2;
    return r;
  endfunction

  function automatic logic signed [63:0] round_sat(input logic signed [63:0] acc,
                                                   input int shift, input int w_out);
    logic signed [63:0] r, hi, lo;
    r = acc;
    if (shift > 0) r = (acc + (64'sd1 <<< (shift - 1))) >>> shift;
    hi = (64'sd1 <<< (w_out - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (w_out - 1));
    if (r > hi) r = hi;
    else if (r < lo) r = lo;
    return r;
  endfunction

endpackage

// File: rtl/fir_poly_par_add_tree.sv
// Registered binary adder tree: one level per cycle, each level one bit wider.
// Level l only loads when en[l-1] flags valid data at its input; otherwise it holds.
module fir_add_tree
  import fir_pkg::*;
#(
  parameter int N = 4,
  parameter int W = 8,
  localparam int LV = clog2(N)
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic [LV-1:0]     en,
  input  logic [N*W-1:0]    ops_dat,
  output logic [W+LV-1:0]   sum_dat
);

  for (genvar l = 1; l <= LV; l++) begin : g_lvl
    localparam int NI = tree_nodes(N, l - 1);
    localparam int NO = tree_nodes(N, l);
    localparam int WI = W + l - 1;
    localparam int WO = W + l;

    logic [NI*WI-1:0] opd;
    logic [NO*WO-1:0] sum_d, sum_q;

    if (l == 1) begin : g_in
      assign opd = ops_dat;
    end else begin : g_prev
      assign opd = g_lvl[l-1].sum_q;
    end

    always_comb begin
      sum_d = sum_q;
      if (en[l-1]) begin
        for (int k = 0; k < NI / 2; k++) begin
          sum_d[k*WO +: WO] = WO'($signed(opd[(2*k)*WI +: WI]))
                            + WO'($signed(opd[(2*k+1)*WI +: WI]));
        end
        if (NI % 2 == 1) sum_d[(NO-1)*WO +: WO] = WO'($signed(opd[(NI-1)*WI +: WI]));
      end
    end

    always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) sum_q <= '0;
      else       sum_q <= sum_d;
    end
  end

  assign sum_dat = g_lvl[LV].sum_q;

endmodule

// File: rtl/fir_poly_par.sv
// P-lane parallel FIR with cross-beat history and shadow/active coefficient banks.
// Latency 1+clog2(NTAP) (+1 with FIR_ROUND_EN: shift, round-half-up, saturate); no backpressure.
module fir_poly_par
  import fir_pkg::*;
#(
  parameter int P     = 6,
  parameter int NTAP  = 4,
  parameter int W_IN  = 5,
  parameter int W_C   = 3,
  parameter int W_OUT = 12,
  parameter int SHIFT = 0
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic                     in_valid,
  input  logic [P*W_IN-1:0]        x_in,
  input  logic                     hist_clr,
  input  logic                     coef_we,
  input  logic [clog2(NTAP)-1:0]   coef_addr,
  input  logic signed [W_C-1:0]    coef_data,
  input  logic                     coef_commit,
  output logic                     out_valid,
  output logic [P*W_OUT-1:0]       y_out
);

  localparam int W_P   = W_IN + W_C;
  localparam int LV    = clog2(NTAP);
  localparam int W_ACC = w_acc(W_IN, W_C, NTAP);
  localparam int NH    = NTAP - 1;
`ifdef FIR_ROUND_EN
  localparam int NV = lat(NTAP) + 1;
`else
  localparam int NV = lat(NTAP);
`endif

  logic signed [W_IN-1:0] hist_q [NH];
  logic signed [W_IN-1:0] hist_d [NH];
  logic signed [W_C-1:0]  shd_q [NTAP];
  logic signed [W_C-1:0]  shd_d [NTAP];
  logic signed [W_C-1:0]  act_q [NTAP];
  logic signed [W_C-1:0]  act_d [NTAP];
  logic [NTAP*W_P-1:0]    prod_q [P];
  logic [NTAP*W_P-1:0]    prod_d [P];
  logic [NV-1:0]          vld_q, vld_d;
  logic signed [W_IN-1:0] ext [NH+P];
  logic [W_ACC-1:0]       acc [P];

  // ext holds the sample stream oldest-first: history, then this beat's lanes.
  always_comb begin
    for (int m = 0; m < NH; m++) ext[m] = hist_clr ? '0 : hist_q[m];
    for (int j = 0; j < P; j++) ext[NH+j] = x_in[j*W_IN +: W_IN];

    for (int m = 0; m < NH; m++) hist_d[m] = in_valid ? ext[P+m] : ext[m];

    shd_d = shd_q;
    if (coef_we && int'(coef_addr) < NTAP) shd_d[coef_addr] = coef_data;
    act_d = coef_commit ? shd_q : act_q;

    prod_d = prod_q;
    if (in_valid) begin
      for (int j = 0; j < P; j++)
        for (int i = 0; i < NTAP; i++)
          prod_d[j][i*W_P +: W_P] = W_P'(ext[NH+j-i]) * W_P'(act_q[i]);
    end

    vld_d = {vld_q[NV-2:0], in_valid};
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int m = 0; m < NH; m++)   hist_q[m] <= '0;
      for (int i = 0; i < NTAP; i++) begin
        shd_q[i] <= '0;
        act_q[i] <= '0;
      end
      for (int j = 0; j < P; j++)    prod_q[j] <= '0;
      vld_q <= '0;
    end else begin
      hist_q <= hist_d;
      shd_q  <= shd_d;
      act_q  <= act_d;
      prod_q <= prod_d;
      vld_q  <= vld_d;
    end
  end

  for (genvar j = 0; j < P; j++) begin : g_lane
    fir_add_tree #(.N(NTAP), .W(W_P)) u_tree (
      .clk     (clk),
      .rstn    (rstn),
      .en      (vld_q[LV-1:0]),
      .ops_dat (prod_q[j]),
      .sum_dat (acc[j])
    );
  end

  assign out_valid = vld_q[NV-1];

`ifdef FIR_ROUND_EN
  logic [W_OUT-1:0] yr_q [P];
  logic [W_OUT-1:0] yr_d [P];

  always_comb begin
    yr_d = yr_q;
    if (vld_q[LV]) begin
      for (int j = 0; j < P; j++)
        yr_d[j] = W_OUT'(round_sat(64'($signed(acc[j])), SHIFT, W_OUT));
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int j = 0; j < P; j++) yr_q[j] <= '0;
    end else begin
      yr_q <= yr_d;
    end
  end

  for (genvar j = 0; j < P; j++) begin : g_out
    assign y_out[j*W_OUT +: W_OUT] = yr_q[j];
  end
`else
  // Full-precision path; SHIFT only has meaning on the rounding path.
  if (SHIFT >= 0) begin : g_full
    for (genvar j = 0; j < P; j++) begin : g_out
      assign y_out[j*W_OUT +: W_OUT] = W_OUT'($signed(acc[j]));
    end
  end
`endif

endmodule

// File: tb/tb_fir_poly_par.sv
// Randomised bench for fir_poly_par against a sample-stream convolution model,
// plus literal expectations from the directed scenarios (either FIR_ROUND_EN setting).
module tb_fir_poly_par;

  localparam int P    = 6;
  localparam int NTAP = 4;
  localparam int W_IN = 5;
  localparam int W_C  = 3;
  localparam int AW   = 2;
`ifdef FIR_ROUND_EN
  localparam int W_OUT = 6;
  localparam int SHIFT = 2;
  localparam int LAT   = 4;
`else
  localparam int W_OUT = 12;
  localparam int SHIFT = 0;
  localparam int LAT   = 3;
`endif

  logic                  clk = 0;
  logic                  rstn = 0;
  logic                  in_valid = 0;
  logic [P*W_IN-1:0]     x_in = '0;
  logic                  hist_clr = 0;
  logic                  coef_we = 0;
  logic [AW-1:0]         coef_addr = '0;
  logic signed [W_C-1:0] coef_data = '0;
  logic                  coef_commit = 0;
  logic                  out_valid;
  logic [P*W_OUT-1:0]    y_out;

  fir_poly_par #(.P(P), .NTAP(NTAP), .W_IN(W_IN), .W_C(W_C), .W_OUT(W_OUT), .SHIFT(SHIFT)) dut (
    .clk(clk), .rstn(rstn), .in_valid(in_valid), .x_in(x_in), .hist_clr(hist_clr),
    .coef_we(coef_we), .coef_addr(coef_addr), .coef_data(coef_data),
    .coef_commit(coef_commit), .out_valid(out_valid), .y_out(y_out)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference state: sample stream since last clear, coefficient banks, output delay line.
  int                 xs[$];
  int                 act[NTAP];
  int                 shd[NTAP];
  logic [LAT-1:0]     pv;
  logic [P*W_OUT-1:0] py [LAT];
  logic [P*W_OUT-1:0] last_y;
  int                 lit[P];

  function automatic int expect_out(input int a);
    int r, hi, lo;
    r = a;
`ifdef FIR_ROUND_EN
    if (SHIFT > 0) r = (a + (1 << (SHIFT - 1))) >>> SHIFT;
    hi = (1 << (W_OUT - 1)) - 1;
    lo = -(1 << (W_OUT - 1));
    if (r > hi) r = hi;
    if (r < lo) r = lo;
`else
    hi = 0;
    lo = 0;
`endif
    return r + hi * 0 + lo * 0;
  endfunction

  task automatic model_reset();
    xs.delete();
    for (int i = 0; i < NTAP; i++) begin
      act[i] = 0;
      shd[i] = 0;
    end
    pv = '0;
    for (int k = 0; k < LAT; k++) py[k] = '0;
    last_y = '0;
  endtask

  task automatic model_edge(input logic v, input logic [P*W_IN-1:0] x, input logic clr,
                            input logic we, input logic [AW-1:0] a, input int d, input logic cm);
    logic [P*W_OUT-1:0] ypk;
    logic signed [W_C-1:0] cd;
    int n, s, idx;
    ypk = '0;
    if (clr) xs.delete();
    if (v) begin
      for (int j = 0; j < P; j++) begin
        s = $signed(x[j*W_IN +: W_IN]);
        xs.push_back(s);
      end
      n = xs.size();
      for (int j = 0; j < P; j++) begin
        s = 0;
        for (int i = 0; i < NTAP; i++) begin
          idx = n - P + j - i;
          if (idx >= 0) s += act[i] * xs[idx];
        end
        ypk[j*W_OUT +: W_OUT] = W_OUT'(expect_out(s));
      end
      while (xs.size() > 64) void'(xs.pop_front());
    end
    for (int k = LAT - 1; k > 0; k--) begin
      pv[k] = pv[k-1];
      py[k] = py[k-1];
    end
    pv[0] = v;
    py[0] = ypk;
    if (pv[LAT-1]) last_y = py[LAT-1];
    if (cm) for (int i = 0; i < NTAP; i++) act[i] = shd[i];
    if (we) begin
      cd = d[W_C-1:0];
      shd[a] = cd;
    end
  endtask

  task automatic step(input logic v, input logic [P*W_IN-1:0] x, input logic clr,
                      input logic we, input logic [AW-1:0] a, input int d, input logic cm);
    in_valid = v; x_in = x; hist_clr = clr;
    coef_we = we; coef_addr = a; coef_data = d[W_C-1:0]; coef_commit = cm;
    @(posedge clk);
    model_edge(v, x, clr, we, a, d, cm);
    #1;
  endtask

  task automatic beat(input logic [P*W_IN-1:0] x);
    step(1'b1, x, 1'b0, 1'b0, '0, 0, 1'b0);
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step(1'b0, '0, 1'b0, 1'b0, '0, 0, 1'b0);
  endtask

  function automatic logic [P*W_IN-1:0] fill(input int v);
    logic [P*W_IN-1:0] r;
    for (int j = 0; j < P; j++) r[j*W_IN +: W_IN] = W_IN'(v);
    return r;
  endfunction

  task automatic check_lanes(input string name);
    int got, mdl;
    checks++;
    if (out_valid !== 1'b1) begin
      errors++;
      $display("FAIL %s out_valid got %b want 1", name, out_valid);
    end
    for (int j = 0; j < P; j++) begin
      got = $signed(y_out[j*W_OUT +: W_OUT]);
      mdl = $signed(last_y[j*W_OUT +: W_OUT]);
      checks++;
      if (got != lit[j]) begin
        errors++;
        $display("FAIL %s lane%0d dut got %0d want %0d", name, j, got, lit[j]);
      end
      checks++;
      if (mdl != lit[j]) begin
        errors++;
        $display("FAIL %s lane%0d model got %0d want %0d", name, j, mdl, lit[j]);
      end
    end
  endtask

  task automatic check_fn(input string name, input int a, input int want);
    int got;
    got = expect_out(a);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s got %0d want %0d", name, got, want);
    end
  endtask

  // Every cycle: DUT outputs against the delayed reference.
  always @(negedge clk) begin
    checks++;
    if (out_valid !== pv[LAT-1]) begin
      errors++;
      $display("FAIL cyc_valid got %b want %b at %0t", out_valid, pv[LAT-1], $time);
    end
    checks++;
    if (y_out !== last_y) begin
      errors++;
      $display("FAIL cyc_y got %h want %h at %0t", y_out, last_y, $time);
    end
  end

  initial begin
    logic [P*W_IN-1:0] xr;
    model_reset();
    #12;
    checks++;
    if (out_valid !== 1'b0 || y_out !== '0) begin
      errors++;
      $display("FAIL reset got v=%b y=%h want 0", out_valid, y_out);
    end
    rstn = 1;
    @(negedge clk);

`ifdef FIR_ROUND_EN
    check_fn("rnd6", 6, 2);
    check_fn("rnd511", 511, 31);
    check_fn("rndm512", -512, -32);
`else
    check_fn("ext6", 6, 6);
    check_fn("ext511", 511, 511);
    check_fn("extm512", -512, -512);
`endif

    // Impulse response with c = 0,1,2,3
    for (int i = 0; i < NTAP; i++) step(1'b0, '0, 1'b0, 1'b1, AW'(i), i, 1'b0);
    step(1'b0, '0, 1'b0, 1'b0, '0, 0, 1'b1);
    xr = '0; xr[W_IN-1:0] = W_IN'(1);
    beat(xr);
    beat('0);
    idle(LAT - 2);
`ifdef FIR_ROUND_EN
    lit = '{0, 0, 1, 1, 0, 0};
`else
    lit = '{0, 1, 2, 3, 0, 0};
`endif
    check_lanes("impulse");
    idle(1);
    lit = '{0, 0, 0, 0, 0, 0};
    check_lanes("impulse_zero");

    // Sample in lane 5 spills into the next beat
    xr = '0; xr[5*W_IN +: W_IN] = W_IN'(1);
    beat(xr);
    beat('0);
    idle(LAT - 2);
    lit = '{0, 0, 0, 0, 0, 0};
    check_lanes("cross_k");
    idle(1);
`ifdef FIR_ROUND_EN
    lit = '{0, 1, 1, 0, 0, 0};
`else
    lit = '{1, 2, 3, 0, 0, 0};
`endif
    check_lanes("cross_k1");

    // Extremes: x=-16, c=-4 steady
    for (int i = 0; i < NTAP; i++) step(1'b0, '0, 1'b0, 1'b1, AW'(i), -4, 1'b0);
    step(1'b0, '0, 1'b0, 1'b0, '0, 0, 1'b1);
    for (int k = 0; k < 4; k++) beat(fill(-16));
    idle(LAT - 1);
`ifdef FIR_ROUND_EN
    lit = '{31, 31, 31, 31, 31, 31};
`else
    lit = '{256, 256, 256, 256, 256, 256};
`endif
    check_lanes("extreme");

    // Shadow writes mid-stream, commit alongside a beat
    for (int i = 0; i < NTAP; i++) step(1'b1, fill(-16), 1'b0, 1'b1, AW'(i), 3, 1'b0);
    idle(2);
    step(1'b1, fill(1), 1'b0, 1'b0, '0, 0, 1'b1);
    beat(fill(1));
    idle(LAT - 1);
`ifdef FIR_ROUND_EN
    lit = '{3, 3, 3, 3, 3, 3};
`else
    lit = '{12, 12, 12, 12, 12, 12};
`endif
    check_lanes("commit");

    // Random traffic: bubbles, clears, coefficient writes and commits
    for (int c = 0; c < 1500; c++) begin
      for (int j = 0; j < P; j++) xr[j*W_IN +: W_IN] = W_IN'($urandom_range(0, 31));
      step($urandom_range(0, 9) < 7, xr, $urandom_range(0, 19) == 0,
           $urandom_range(0, 3) == 0, AW'($urandom_range(0, NTAP - 1)),
           int'($urandom_range(0, 7)) - 4, $urandom_range(0, 9) == 0);
    end

    // Reset with beats in flight
    for (int k = 0; k < 3; k++) beat(fill(7));
    rstn = 0;
    model_reset();
    #1;
    checks++;
    if (out_valid !== 1'b0 || y_out !== '0) begin
      errors++;
      $display("FAIL midreset got v=%b y=%h want 0", out_valid, y_out);
    end
    @(negedge clk);
    @(negedge clk);
    rstn = 1;
    #1;
    beat(fill(5));
    beat(fill(-3));
    idle(LAT - 1);
    lit = '{0, 0, 0, 0, 0, 0};
    check_lanes("post_reset");
    idle(2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fir_poly_par.md
Name: fir_poly_par

Overview:
Parametrised P-lane parallel FIR filter for the DWT filter bank. Each valid beat carries P consecutive samples x[Pk..Pk+P-1]; the block produces P outputs y[Pk+j] = sum_{i=0}^{NTAP-1} c_i*x[Pk+j-i]. It replaces the fixed 4-tap, single-output polyphase cells with one block that adds valid handshake, cross-beat history, a pipelined adder tree and run-time reloadable coefficients held in a shadow bank.

Parameters:
P, 6, parallel lanes (samples per beat), >=1
NTAP, 4, filter taps, >=2
W_IN, 5, signed sample width
W_C, 3, signed coefficient width
W_OUT, 12, signed output width; without FIR_ROUND_EN must be >= W_ACC = W_IN+W_C+clog2(NTAP)
SHIFT, 0, right shift applied to each output, used only with FIR_ROUND_EN

Ports:
clk  in  1  clock
rstn  in  1  asynchronous active-low reset
in_valid  in  1  input beat valid
x_in  in  P*W_IN  samples; lane j at [j*W_IN +: W_IN] = x[Pk+j]
hist_clr  in  1  synchronous clear of sample history
coef_we  in  1  shadow coefficient write strobe
coef_addr  in  clog2(NTAP)  shadow tap index
coef_data  in  W_C  signed coefficient value
coef_commit  in  1  copy shadow bank to active bank
out_valid  out  1  output beat valid
y_out  out  P*W_OUT  outputs; lane j at [j*W_OUT +: W_OUT]

Behaviour:
- Reset (asynchronous, rstn=0): history, active and shadow coefficients, all pipeline registers, out_valid, y_out cleared to 0.
- History: last NTAP-1 samples of the previous accepted beat; updated only when in_valid=1. in_valid=0 bubbles leave history and results unaffected (no state advance).
- hist_clr=1: history zeroed at the clock edge; if in_valid is also 1, that beat is computed using zero history and its own samples become the new history.
- Stage 1: P*NTAP products registered, full width W_IN+W_C, signed, using the active bank at that edge.
- Stages 2..1+clog2(NTAP): registered binary adder tree, one level per stage, widths grow 1 bit per level; odd operand passed through, sign-extended.
- Latency LAT = 1+clog2(NTAP) cycles from in_valid to out_valid (defaults: 3). Throughput one beat per cycle; no backpressure.
- Without macro: y_out lane = accumulator sign-extended to W_OUT.
- Coefficients: coef_we writes shadow[coef_addr]; out-of-range addr ignored. coef_commit copies shadow to active at the edge; a beat with in_valid in the commit cycle uses the OLD bank, the next beat uses the new one. coef_we and coef_commit in the same cycle: commit copies the pre-write shadow; write lands in shadow only.
- Beats in flight are never corrupted by commit (coefficients consumed at stage 1 only).
- out_valid is a delayed copy of in_valid through LAT registers; y_out holds its last value when out_valid=0.

Optional Feature:
FIR_ROUND_EN defined: one extra output stage (LAT+1); each accumulator arithmetic-shifted right by SHIFT with round-half-up (add 2^(SHIFT-1) when SHIFT>0), then saturated to [-2^(W_OUT-1), 2^(W_OUT-1)-1]. W_OUT may be below W_ACC. Undefined: no rounding stage, SHIFT ignored, full-precision sign-extended output.

Decomposition:
- Package fir_pkg: clog2 function, W_ACC and LAT derivation functions, saturate/round function.
- One sub-module fir_add_tree (registered, parametrised by operand count and width), instantiated once per lane.

Test Plan:
- Impulse: commit c=0,1,2,3; beat lane0=1 others 0, then zero beat -> 3 cycles later y lanes = 0,1,2,3,0,0; next beat all 0.
- Cross-beat: lane5=1 in beat k, zeros in k+1 -> beat k lane5=0; beat k+1 lanes0..2 = 1,2,3, rest 0.
- Extremes: all x=-16, all c=-4, steady stream -> every lane 256, no overflow.
- Bubbles and commit: insert 2 idle cycles between beats -> outputs identical to gapless run; write shadow 3,3,3,3 mid-stream, commit at cycle t -> beat at t uses old bank, beat t+1 all-ones input yields 12 per lane.
- Reset mid-stream: pull rstn low with 3 beats in flight -> out_valid=0, y_out=0 immediately; after release, first beats output 0 until coefficients reloaded.
- FIR_ROUND_EN, SHIFT=2, W_OUT=6: accumulator 6 -> 2; 511 -> 31 (saturated); -512 -> -32; latency 4.
